// File: rtl/data_convert_read_ctrl.sv
// Read-side sequencer for the 128b->1024b data-convert FIFO: waits for a full
// row to be buffered, bursts it out under back-pressure, then flushes per layer.
module data_convert_read_ctrl #(
    parameter int ADDR_BITS  = 10,
    parameter int RATIO_LOG2 = 3,
    parameter int ROW_BITS   = 10,
    parameter int SETTLE     = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [ADDR_BITS-RATIO_LOG2:0] row_words,
    input  logic [ROW_BITS-1:0]           row_num,
    output logic [ADDR_BITS:0]            M_count,
    input  logic                          M_Ready,
    input  logic                          empty,
    output logic                          rd_en,
    input  logic                          out_ready,
    output logic                          out_valid,
    output logic                          out_last,
    output logic                          Next_Reg,
    output logic                          busy,
    output logic                          done
);

    localparam int WW = ADDR_BITS - RATIO_LOG2 + 1;
    localparam int SW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
    localparam logic [SW-1:0] SETTLE_MAX  = SW'(SETTLE);
    localparam logic [SW-1:0] SETTLE_LAST = (SETTLE > 0) ? SW'(SETTLE - 1) : '0;
    localparam logic [WW-1:0] ONE_W       = WW'(1);
    localparam logic [ROW_BITS-1:0] ONE_R = ROW_BITS'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FILL   = 3'd1,
        ST_BURST  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_FLUSH  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [WW-1:0]       r_words_lat;
    logic [ROW_BITS-1:0] r_rows_lat;
    logic [WW-1:0]       r_word_cnt;
    logic [ROW_BITS-1:0] r_row_cnt;
    logic [SW-1:0]       r_settle_cnt;
    logic [ADDR_BITS:0]  r_m_count;
    logic                r_out_valid;
    logic                r_out_last;

    logic                w_rd_en;
    logic                w_row_end;
    logic                w_settle_last;
    logic                w_last_row;
    logic [WW-1:0]       w_words_in;
    logic [ROW_BITS-1:0] w_rows_in;

    assign w_words_in    = (row_words == '0) ? ONE_W : row_words;
    assign w_rows_in     = (row_num == '0) ? ONE_R : row_num;
    assign w_row_end     = w_rd_en && (r_word_cnt == r_words_lat - ONE_W);
    assign w_settle_last = (r_settle_cnt >= SETTLE_LAST);
    assign w_last_row    = ((r_row_cnt + ONE_R) == r_rows_lat);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_rd_en      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next_state = ST_FILL;
            end
            ST_FILL: begin
                // M_Ready is a registered FIFO flag; give it time to see the new threshold
                if (r_settle_cnt == SETTLE_MAX && M_Ready) w_next_state = ST_BURST;
            end
            ST_BURST: begin
                w_rd_en = !empty && out_ready && (r_word_cnt < r_words_lat);
                if (w_row_end) w_next_state = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (w_settle_last) w_next_state = w_last_row ? ST_FLUSH : ST_FILL;
            end
            ST_FLUSH: begin
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_words_lat  <= '0;
            r_rows_lat   <= '0;
            r_word_cnt   <= '0;
            r_row_cnt    <= '0;
            r_settle_cnt <= '0;
            r_m_count    <= '0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
        end else begin
            // Counter restarts on every state change so each state times from its entry
            if (r_state != w_next_state) begin
                r_settle_cnt <= '0;
            end else if (r_settle_cnt != SETTLE_MAX) begin
                r_settle_cnt <= r_settle_cnt + 1'b1;
            end

            if (r_state == ST_IDLE && start) begin
                r_words_lat <= w_words_in;
                r_rows_lat  <= w_rows_in;
                r_m_count   <= {w_words_in, {RATIO_LOG2{1'b0}}};
                r_row_cnt   <= '0;
                r_word_cnt  <= '0;
            end else if (r_state == ST_SETTLE && w_settle_last) begin
                r_word_cnt <= '0;
                r_row_cnt  <= r_row_cnt + ONE_R;
            end else if (w_rd_en) begin
                r_word_cnt <= r_word_cnt + ONE_W;
            end

            r_out_valid <= w_rd_en;
            r_out_last  <= w_row_end;
        end
    end

    assign rd_en     = w_rd_en;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign M_count   = r_m_count;
    assign busy      = (r_state != ST_IDLE);
    assign Next_Reg  = (r_state == ST_FLUSH);
    assign done      = (r_state == ST_FLUSH);

endmodule
